// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS opcode/funct/rt-field constants and writeback decode types.
package mips_isa_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_MOVZ    = 6'h0A;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;
  localparam logic [4:0] RT_BLTZALL = 5'h12;
  localparam logic [4:0] RT_BGEZALL = 5'h13;

  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_LINK} wb_src_e;
  typedef enum logic [2:0] {LD_B, LD_BU, LD_H, LD_HU, LD_W, LD_WL, LD_WR} ld_kind_e;

  function automatic logic fn_is_alu(input logic [5:0] f);
    return f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                     6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                     6'h2A, 6'h2B};
  endfunction

  // Load opcodes 0x20..0x26 map onto their low three bits.
  function automatic ld_kind_e ld_kind(input logic [2:0] op_lo);
    case (op_lo)
      3'd0:    return LD_B;
      3'd1:    return LD_H;
      3'd2:    return LD_WL;
      3'd3:    return LD_W;
      3'd4:    return LD_BU;
      3'd5:    return LD_HU;
      default: return LD_WR;
    endcase
  endfunction
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: little-endian load alignment, extension and lwl/lwr merge.
module wb_load_align
  import mips_isa_pkg::*;
#(
  parameter bit EN_UNALIGNED = 1
) (
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_rt_old,
  input  logic [1:0]  i_offset,
  input  ld_kind_e    i_kind,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_sh;
  logic [4:0]  w_shl;
  always_comb begin
    w_sh   = {i_offset, 3'b000};
    w_shl  = {~i_offset, 3'b000};
    w_byte = 8'(i_rdata >> w_sh);
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = '0;
    case (i_kind)
      LD_B:  o_data = {{24{w_byte[7]}}, w_byte};
      LD_BU: o_data = {24'h0, w_byte};
      LD_H:  o_data = {{16{w_half[15]}}, w_half};
      LD_HU: o_data = {16'h0, w_half};
      LD_W:  o_data = i_rdata;
      LD_WL: o_data = EN_UNALIGNED ? (i_rdata << w_shl) | (i_rt_old & (32'h00FF_FFFF >> w_sh)) : '0;
      LD_WR: o_data = EN_UNALIGNED ? (i_rdata >> w_sh) | (i_rt_old & ~(32'hFFFF_FFFF >> w_sh)) : '0;
      default: o_data = '0;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: M/W pipeline register, writeback decode, register-file write port
// and retired-instruction counter.
module wb_stage
  import mips_isa_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 32,
  parameter bit EN_UNALIGNED = 1,
  parameter bit EN_MOVZ      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              m_valid,
  input  logic [31:0]       m_instr,
  input  logic [31:0]       m_pc,
  input  logic [31:0]       m_alu,
  input  logic [31:0]       m_rdata,
  input  logic [31:0]       m_rt_old,
  input  logic              m_movz_ok,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  retired
);
  logic             r_valid, r_movz_ok;
  logic [31:0]      r_instr, r_pc, r_alu, r_rdata, r_rt_old;
  logic [CNT_W-1:0] r_retired;
  logic [5:0]       w_op, w_fn;
  logic [4:0]       w_rt, w_rd;
  wb_src_e          w_src;
  ld_kind_e         w_kind;
  logic             w_movz;
  logic [31:0]      w_aligned;
  logic             w_unused;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_pc      <= '0;
      r_alu     <= '0;
      r_rdata   <= '0;
      r_rt_old  <= '0;
      r_movz_ok <= 1'b0;
      r_retired <= '0;
    end else begin
      if (r_valid && !stall) r_retired <= r_retired + 1'b1;
      if (flush) begin
        r_valid <= 1'b0;
        r_instr <= '0;
      end else if (!stall) begin
        r_valid   <= m_valid;
        r_instr   <= m_instr;
        r_pc      <= m_pc;
        r_alu     <= m_alu;
        r_rdata   <= m_rdata;
        r_rt_old  <= m_rt_old;
        r_movz_ok <= m_movz_ok;
      end
    end
  end

  assign w_op     = r_instr[31:26];
  assign w_rt     = r_instr[20:16];
  assign w_rd     = r_instr[15:11];
  assign w_fn     = r_instr[5:0];
  assign w_kind   = ld_kind(w_op[2:0]);
  assign w_unused = ^{r_instr[25:21], r_instr[10:6]};

  always_comb begin
    w_src    = WB_NONE;
    w_movz   = 1'b0;
    rf_waddr = REG_AW'(w_rt);
    case (w_op)
      OP_SPECIAL: begin
        rf_waddr = REG_AW'(w_rd);
        w_movz   = w_fn == FN_MOVZ;
        w_src    = w_fn == FN_JALR ? WB_LINK :
                   w_movz          ? (EN_MOVZ ? WB_ALU : WB_NONE) :
                   fn_is_alu(w_fn) ? WB_ALU : WB_NONE;
      end
      OP_REGIMM: begin
        rf_waddr = '1;
        w_src    = w_rt inside {RT_BLTZAL, RT_BGEZAL, RT_BLTZALL, RT_BGEZALL} ? WB_LINK : WB_NONE;
      end
      OP_JAL: begin
        rf_waddr = '1;
        w_src    = WB_LINK;
      end
      default:
        // lwl/lwr fall back to no-write when the merge path is disabled.
        w_src = w_op[5:3] == 3'b001 ? WB_ALU :
                (w_op[5:3] == 3'b100 && w_op[2:0] != 3'd7) ?
                  ((!EN_UNALIGNED && w_kind inside {LD_WL, LD_WR}) ? WB_NONE : WB_MEM) :
                WB_NONE;
    endcase
  end

  wb_load_align #(.EN_UNALIGNED(EN_UNALIGNED)) u_align (
    .i_rdata  (r_rdata),
    .i_rt_old (r_rt_old),
    .i_offset (r_alu[1:0]),
    .i_kind   (w_kind),
    .o_data   (w_aligned)
  );

  assign rf_wdata  = w_src == WB_MEM ? w_aligned : w_src == WB_LINK ? r_pc + 32'd8 : r_alu;
  assign rf_we     = r_valid && w_src != WB_NONE && rf_waddr != '0 && (!w_movz || r_movz_ok);
  assign fwd_valid = rf_we;
  assign retired   = r_retired;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of wb_stage decode, alignment, stall/flush and counter.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        reset, stall, flush, m_valid, m_movz_ok;
  logic [31:0] m_instr, m_pc, m_alu, m_rdata, m_rt_old;
  logic        rf_we, fwd_valid, rf_we4, fwd_valid4;
  logic [4:0]  rf_waddr, rf_waddr4;
  logic [31:0] rf_wdata, rf_wdata4, retired;
  logic [3:0]  retired4;
  int          n_tests = 0, n_fail = 0;
  bit          w_v;
  logic [31:0] exp_ret;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .m_valid(m_valid),
    .m_instr(m_instr), .m_pc(m_pc), .m_alu(m_alu), .m_rdata(m_rdata),
    .m_rt_old(m_rt_old), .m_movz_ok(m_movz_ok), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .retired(retired)
  );

  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .m_valid(m_valid),
    .m_instr(m_instr), .m_pc(m_pc), .m_alu(m_alu), .m_rdata(m_rdata),
    .m_rt_old(m_rt_old), .m_movz_ok(m_movz_ok), .rf_we(rf_we4), .rf_waddr(rf_waddr4),
    .rf_wdata(rf_wdata4), .fwd_valid(fwd_valid4), .retired(retired4)
  );

  function automatic logic [31:0] rt_i(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (w_v && !stall) exp_ret++;
    w_v = flush ? 1'b0 : stall ? w_v : m_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [31:0] instr, pc, alu, rdata, rt_old, input logic ok);
    m_valid = 1'b1; m_instr = instr; m_pc = pc; m_alu = alu;
    m_rdata = rdata; m_rt_old = rt_old; m_movz_ok = ok; stall = 1'b0; flush = 1'b0;
    tick();
  endtask

  task automatic wr(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, ".we"}, {31'h0, rf_we}, {31'h0, we});
    chk({tag, ".fwd"}, {31'h0, fwd_valid}, {31'h0, we});
    if (we) begin
      chk({tag, ".waddr"}, {27'h0, rf_waddr}, addr);
      chk({tag, ".wdata"}, rf_wdata, data);
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; m_valid = 1'b0; m_movz_ok = 1'b0;
    m_instr = '0; m_pc = '0; m_alu = '0; m_rdata = '0; m_rt_old = '0;
    w_v = 1'b0; exp_ret = '0;
    #12;
    chk("rst.we", {31'h0, rf_we}, 32'h0);
    chk("rst.waddr", {27'h0, rf_waddr}, 32'h0);
    chk("rst.wdata", rf_wdata, 32'h0);
    chk("rst.fwd", {31'h0, fwd_valid}, 32'h0);
    chk("rst.retired", retired, 32'h0);
    reset = 1'b1;
    ld(rt_i(1, 2, 3, 6'h21), 32'h100, 32'h7, 0, 0, 0);
    wr("addu0", 1, 3, 32'h7);
    ld(rt_i(1, 2, 5, 6'h21), 32'h104, 32'h9, 0, 0, 0);
    chk("pre_rst.retired", retired, 32'h1);
    // Asynchronous reset mid-cycle with a valid instruction in W.
    #3 reset = 1'b0;
    #1;
    chk("async.we", {31'h0, rf_we}, 32'h0);
    chk("async.retired", retired, 32'h0);
    w_v = 1'b0; exp_ret = '0;
    #2 reset = 1'b1;
    ld(rt_i(1, 2, 3, 6'h21), 32'h100, 32'h7, 0, 0, 0);
    wr("addu1", 1, 3, 32'h7);
    ld(it_i(6'h20, 0, 4, 0), 0, 32'h1003, 32'h80FF1234, 0, 0);
    wr("lb", 1, 4, 32'hFFFFFF80);
    ld(it_i(6'h24, 0, 4, 0), 0, 32'h1003, 32'h80FF1234, 0, 0);
    wr("lbu", 1, 4, 32'h00000080);
    ld(it_i(6'h21, 0, 4, 0), 0, 32'h1002, 32'h80FF1234, 0, 0);
    wr("lh", 1, 4, 32'hFFFF80FF);
    ld(it_i(6'h25, 0, 4, 0), 0, 32'h1001, 32'h80FF1234, 0, 0);
    wr("lhu", 1, 4, 32'h00001234);
    ld(it_i(6'h20, 0, 4, 0), 0, 32'h1000, 32'h80FF1234, 0, 0);
    wr("lb0", 1, 4, 32'h00000034);
    ld(it_i(6'h23, 0, 4, 0), 0, 32'h1000, 32'h80FF1234, 0, 0);
    wr("lw", 1, 4, 32'h80FF1234);
    ld(it_i(6'h22, 0, 6, 0), 0, 32'h1001, 32'hAABBCCDD, 32'h11223344, 0);
    wr("lwl1", 1, 6, 32'hCCDD3344);
    ld(it_i(6'h26, 0, 6, 0), 0, 32'h1001, 32'hAABBCCDD, 32'h11223344, 0);
    wr("lwr1", 1, 6, 32'h11AABBCC);
    ld(it_i(6'h22, 0, 6, 0), 0, 32'h1003, 32'hAABBCCDD, 32'h11223344, 0);
    wr("lwl3", 1, 6, 32'hAABBCCDD);
    ld(it_i(6'h22, 0, 6, 0), 0, 32'h1000, 32'hAABBCCDD, 32'h11223344, 0);
    wr("lwl0", 1, 6, 32'hDD223344);
    ld(it_i(6'h26, 0, 6, 0), 0, 32'h1000, 32'hAABBCCDD, 32'h11223344, 0);
    wr("lwr0", 1, 6, 32'hAABBCCDD);
    ld({6'h03, 26'h0000C00}, 32'h00003000, 0, 0, 0, 0);
    wr("jal", 1, 31, 32'h00003008);
    ld(it_i(6'h01, 5, 5'h11, 16'h4), 32'h00004000, 0, 0, 0, 0);
    wr("bgezal", 1, 31, 32'h00004008);
    ld(rt_i(5, 0, 7, 6'h09), 32'hFFFFFFFC, 0, 0, 0, 0);
    wr("jalr_wrap", 1, 7, 32'h00000004);
    ld(rt_i(1, 2, 8, 6'h0A), 0, 32'h55, 0, 0, 0);
    wr("movz_no", 0, 0, 0);
    chk("movz_no.retired", retired, exp_ret);
    ld(rt_i(1, 2, 8, 6'h0A), 0, 32'h55, 0, 0, 1);
    wr("movz_yes", 1, 8, 32'h55);
    chk("movz_counted.retired", retired, exp_ret);
    ld(it_i(6'h2B, 1, 2, 0), 0, 32'h10, 0, 0, 0);
    wr("sw", 0, 0, 0);
    ld(it_i(6'h04, 1, 2, 0), 0, 0, 0, 0, 0);
    wr("beq", 0, 0, 0);
    ld({6'h02, 26'h10}, 0, 0, 0, 0, 0);
    wr("j", 0, 0, 0);
    ld(it_i(6'h09, 1, 0, 5), 0, 32'h5, 0, 0, 0);
    wr("addiu0", 0, 0, 0);
    ld(it_i(6'h09, 1, 9, 5), 0, 32'h5, 0, 0, 0);
    wr("addiu9", 1, 9, 32'h5);
    ld(it_i(6'h23, 0, 10, 0), 0, 32'h2000, 32'hCAFEF00D, 0, 0);
    wr("lw_st", 1, 10, 32'hCAFEF00D);
    chk("lw_st.retired", retired, exp_ret);
    m_instr = rt_i(1, 2, 11, 6'h21); m_alu = 32'h77; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      wr("stall", 1, 10, 32'hCAFEF00D);
      chk("stall.retired", retired, exp_ret);
    end
    stall = 1'b0;
    tick();
    chk("unstall.retired", retired, exp_ret);
    wr("unstall", 1, 11, 32'h77);
    stall = 1'b1; flush = 1'b1;
    tick();
    wr("flush_stall", 0, 0, 0);
    chk("flush_stall.retired", retired, exp_ret);
    stall = 1'b0; flush = 1'b0; m_valid = 1'b0; m_instr = '0;
    tick();
    chk("bubble.retired", retired, exp_ret);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    w_v = 1'b0; exp_ret = '0;
    for (int c = 0; c < 16; c++) ld(it_i(6'h09, 1, 1, 16'(c)), 0, 32'(c), 0, 0, 0);
    chk("wrap15.retired4", {28'h0, retired4}, 32'd15);
    m_valid = 1'b0; m_instr = '0;
    tick();
    chk("wrap.retired4", {28'h0, retired4}, 32'd0);
    chk("wrap.retired", retired, 32'd16);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
